// File: rtl/payout_controller_if.sv
// payout_controller_if
// Groups the vend/payout signals between the vending FSM, the product
// motor/sensor, the coin hopper and the payout controller.
//   slave  : the payout controller side
//   master : the environment side (vending FSM, sensor, hopper)
// Signals:
//   dispense/change       vend request pulse with change owed (units of Rs5)
//   motor_on/vend_done    product motor drive and delivered-item pulse
//   coin_valid/coin_out/coin_ready  coin eject handshake to the hopper
//   hopper10_empty        Rs10 hopper out of stock
//   busy/pending/overflow/fault     status
interface payout_controller_if;
  logic       dispense;
  logic [1:0] change;
  logic       motor_on;
  logic       vend_done;
  logic       coin_valid;
  logic [1:0] coin_out;
  logic       coin_ready;
  logic       hopper10_empty;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;
  logic       fault;

  modport slave (
    input  dispense, change, vend_done, coin_ready, hopper10_empty,
    output motor_on, coin_valid, coin_out, busy, pending, overflow, fault
  );

  modport master (
    output dispense, change, vend_done, coin_ready, hopper10_empty,
    input  motor_on, coin_valid, coin_out, busy, pending, overflow, fault
  );
endinterface

// File: rtl/payout_controller.sv
// payout_controller
// Queues vend requests (with change owed) in a 4-entry FIFO and serves
// them one at a time: run the product motor until the sensor reports
// delivery, then pay the change out coin by coin through a valid/ready
// handshake with the hopper. A vend that never completes within 200
// cycles locks the block in FAULT until reset.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    payout_controller_if.slave (request, motor, hopper, status)
module payout_controller (
  input  logic                       clk,
  input  logic                       reset,
  payout_controller_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, VEND, PAY, FAULT} state_t;

  state_t     state;
  logic [1:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic [1:0] remaining;
  logic [7:0] vend_cnt;
  logic       motor_on;
  logic       coin_valid;
  logic [1:0] coin_out;
  logic       overflow;
  logic       fault;

  logic       pop;
  logic       push_ok;
  logic [1:0] rem_after;

  // Rs10 only while at least two units are owed and the Rs10 hopper has stock.
  function automatic logic [1:0] pick_coin(input logic [1:0] rem,
                                           input logic       empty10);
    return ((rem >= 2'd2) && !empty10) ? 2'b10 : 2'b01;
  endfunction

  // A full queue can still take a push in the cycle IDLE pops its head.
  assign pop     = (state == IDLE) && (count != 3'd0);
  assign push_ok = bus.dispense && ((count != 3'd4) || pop);

  // The coin_out encoding equals its value in Rs5 units.
  assign rem_after = remaining - coin_out;

  // Request FIFO with sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 2'b00;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= bus.change;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (bus.dispense && !push_ok) overflow <= 1'b1;
      count <= count + {2'b00, push_ok} - {2'b00, pop};
    end
  end

  // Service FSM; motor and coin outputs are registered so they change
  // together with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      remaining  <= 2'd0;
      vend_cnt   <= 8'd0;
      motor_on   <= 1'b0;
      coin_valid <= 1'b0;
      coin_out   <= 2'b00;
      fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            remaining <= fifo_mem[rd_ptr];
            vend_cnt  <= 8'd0;
            motor_on  <= 1'b1;
            state     <= VEND;
          end
        end
        VEND: begin
          // Delivery in the same cycle as the timeout still counts as success.
          if (bus.vend_done) begin
            motor_on <= 1'b0;
            if (remaining != 2'd0) begin
              coin_valid <= 1'b1;
              coin_out   <= pick_coin(remaining, bus.hopper10_empty);
              state      <= PAY;
            end else begin
              state <= IDLE;
            end
          end else if (vend_cnt == 8'd200) begin
            motor_on <= 1'b0;
            fault    <= 1'b1;
            state    <= FAULT;
          end else begin
            vend_cnt <= vend_cnt + 8'd1;
          end
        end
        PAY: begin
          // coin_out is only re-chosen after an accepted coin, so hopper
          // stock changes during a stalled handshake cannot alter it.
          if (bus.coin_ready) begin
            remaining <= rem_after;
            if (rem_after == 2'd0) begin
              coin_valid <= 1'b0;
              coin_out   <= 2'b00;
              state      <= IDLE;
            end else begin
              coin_out <= pick_coin(rem_after, bus.hopper10_empty);
            end
          end
        end
        FAULT: begin
          motor_on   <= 1'b0;
          coin_valid <= 1'b0;
          coin_out   <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.motor_on   = motor_on;
  assign bus.coin_valid = coin_valid;
  assign bus.coin_out   = coin_out;
  assign bus.pending    = count;
  assign bus.overflow   = overflow;
  assign bus.fault      = fault;
  assign bus.busy       = (state != IDLE) || (count != 3'd0);

endmodule
